// File: rtl/rgb_sort_pkg.sv
// rgb_sort_pkg
// Shared definitions for the RGB block sorter: colour/ID widths, the FSM
// state type and the fixed table of 16 reference tile colours.
// Colours are packed {R[23:16], G[15:8], B[7:0]}.
package rgb_sort_pkg;

  localparam int NUM_BLK = 16;
  localparam int ID_W    = 4;
  localparam int COL_W   = 24;
  localparam int DIST_W  = 10;
  localparam int ORDER_W = NUM_BLK * ID_W;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Reference colours indexed by tile ID. The concatenation lists ID 15
  // first because it lands in the most significant slot of the packed array.
  localparam logic [NUM_BLK-1:0][COL_W-1:0] REF_TABLE = {
    24'h000000,  // 15
    24'h0000ff,  // 14
    24'h007f00,  // 13
    24'h007fff,  // 12
    24'h00ff00,  // 11
    24'h00ffff,  // 10
    24'h7f0000,  // 9
    24'h7f00ff,  // 8
    24'h7f7f00,  // 7
    24'h7fff00,  // 6
    24'hff0000,  // 5
    24'hff00ff,  // 4
    24'hff7f00,  // 3
    24'hffff00,  // 2
    24'hffffff,  // 1
    24'hff7fff   // 0
  };

endpackage

// File: rtl/rgb_l1_dist.sv
// rgb_l1_dist
// Combinational L1 (Manhattan) distance between two 24-bit RGB colours.
// Ports:
//   col_a_i : first colour  {R,G,B}
//   col_b_i : second colour {R,G,B}
//   dist_o  : |dR| + |dG| + |dB|, at most 765 so 10 bits never overflow
module rgb_l1_dist
  import rgb_sort_pkg::*;
(
  input  logic [COL_W-1:0]  col_a_i,
  input  logic [COL_W-1:0]  col_b_i,
  output logic [DIST_W-1:0] dist_o
);

  logic [7:0] diffR;
  logic [7:0] diffG;
  logic [7:0] diffB;

  function automatic logic [7:0] absDiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Per-channel magnitudes are zero-extended before summing so the carry
  // out of the 8-bit channels is kept.
  always_comb begin
    diffR  = absDiff(col_a_i[23:16], col_b_i[23:16]);
    diffG  = absDiff(col_a_i[15:8],  col_b_i[15:8]);
    diffB  = absDiff(col_a_i[7:0],   col_b_i[7:0]);
    dist_o = {2'b00, diffR} + {2'b00, diffG} + {2'b00, diffB};
  end

endmodule

// File: rtl/rgb_block_sorter.sv
// rgb_block_sorter
// Classifies 16 sampled tile colours to the nearest of 16 reference colours,
// one (block, reference) comparison per clock, and packs the resulting tile
// IDs into a 64-bit order word.
// Ports:
//   i_clk                : clock, rising edge
//   i_rst                : synchronous reset, active-high
//   i_start              : start request, only honoured while idle
//   i_block0..i_block15  : sampled block colours, captured on accepted start
//   o_order              : tile IDs, block i in o_order[63-4i -: 4]
//   o_done               : one-cycle pulse when o_order is complete
module rgb_block_sorter
  import rgb_sort_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [COL_W-1:0]   i_block0,
  input  logic [COL_W-1:0]   i_block1,
  input  logic [COL_W-1:0]   i_block2,
  input  logic [COL_W-1:0]   i_block3,
  input  logic [COL_W-1:0]   i_block4,
  input  logic [COL_W-1:0]   i_block5,
  input  logic [COL_W-1:0]   i_block6,
  input  logic [COL_W-1:0]   i_block7,
  input  logic [COL_W-1:0]   i_block8,
  input  logic [COL_W-1:0]   i_block9,
  input  logic [COL_W-1:0]   i_block10,
  input  logic [COL_W-1:0]   i_block11,
  input  logic [COL_W-1:0]   i_block12,
  input  logic [COL_W-1:0]   i_block13,
  input  logic [COL_W-1:0]   i_block14,
  input  logic [COL_W-1:0]   i_block15,
  output logic [ORDER_W-1:0] o_order,
  output logic               o_done
);

  localparam logic [ID_W-1:0]   LAST_IDX = ID_W'(NUM_BLK - 1);
  localparam logic [DIST_W-1:0] MAX_DIST = '1;

  state_e              state_q;
  logic [ID_W-1:0]     blkIdx_q;
  logic [ID_W-1:0]     refIdx_q;
  logic [DIST_W-1:0]   minDist_q;
  logic [ID_W-1:0]     minId_q;
  logic [ORDER_W-1:0]  order_q;
  logic                done_q;
  logic [COL_W-1:0]    colours_q [NUM_BLK];

  logic [COL_W-1:0]    blockIn [NUM_BLK];
  logic [COL_W-1:0]    curColour;
  logic [COL_W-1:0]    refColour;
  logic [DIST_W-1:0]   curDist;
  logic                takeNew;
  logic [DIST_W-1:0]   minDist_d;
  logic [ID_W-1:0]     minId_d;
  logic [ORDER_W-1:0]  order_d;

  assign blockIn = '{i_block0,  i_block1,  i_block2,  i_block3,
                     i_block4,  i_block5,  i_block6,  i_block7,
                     i_block8,  i_block9,  i_block10, i_block11,
                     i_block12, i_block13, i_block14, i_block15};

  // Snapshot of the block colours taken on the accepted start, so the source
  // is free to change them for the rest of the run.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state_q == IDLE && i_start) begin
      for (int i = 0; i < NUM_BLK; i++) begin
        colours_q[i] <= blockIn[i];
      end
    end
  end

  always_comb begin
    curColour = colours_q[blkIdx_q];
    refColour = REF_TABLE[refIdx_q];
  end

  rgb_l1_dist u_dist (
    .col_a_i (curColour),
    .col_b_i (refColour),
    .dist_o  (curDist)
  );

  // Strict less-than: an equal distance never displaces an earlier (lower)
  // reference ID. The order word with the current block's nibble replaced
  // by the resolved winner is prepared here and committed on the last
  // reference of each block.
  always_comb begin
    takeNew   = (curDist < minDist_q);
    minDist_d = takeNew ? curDist : minDist_q;
    minId_d   = takeNew ? refIdx_q : minId_q;
    order_d   = order_q;
    for (int i = 0; i < NUM_BLK; i++) begin
      if (blkIdx_q == ID_W'(i)) begin
        order_d[ORDER_W-1-ID_W*i -: ID_W] = minId_d;
      end
    end
  end

  // Control FSM: IDLE waits for start, RUN walks 16 blocks x 16 references.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      blkIdx_q  <= '0;
      refIdx_q  <= '0;
      minDist_q <= '0;
      minId_q   <= '0;
      order_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            blkIdx_q  <= '0;
            refIdx_q  <= '0;
            minDist_q <= MAX_DIST;
            minId_q   <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (refIdx_q == LAST_IDX) begin
            order_q   <= order_d;
            minDist_q <= MAX_DIST;
            minId_q   <= '0;
            refIdx_q  <= '0;
            blkIdx_q  <= blkIdx_q + 1'b1;
            if (blkIdx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            minDist_q <= minDist_d;
            minId_q   <= minId_d;
            refIdx_q  <= refIdx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_order = order_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_rgb_block_sorter.sv
// tb_rgb_block_sorter
// Directed vectors with hand-computed tile orders, plus hand-written
// sequences for start-during-run, hold-after-done, mid-run reset and
// a continuously held start.
module tb_rgb_block_sorter;

  localparam int DONE_LATENCY = 256;
  localparam int WAIT_LIMIT   = 400;

  typedef struct {
    string              name;
    logic [15:0][23:0]  colours;
    logic [63:0]        expOrder;
  } vector_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] blocks [16];
  logic [63:0] order;
  logic        done;

  int passCount  = 0;
  int checkCount = 0;

  vector_t     vecs [4];
  logic [23:0] exactCols [16];
  logic [15:0][23:0] zeroCols;
  logic [63:0] expExact;

  always #5 clk = ~clk;

  rgb_block_sorter dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_block0  (blocks[0]),
    .i_block1  (blocks[1]),
    .i_block2  (blocks[2]),
    .i_block3  (blocks[3]),
    .i_block4  (blocks[4]),
    .i_block5  (blocks[5]),
    .i_block6  (blocks[6]),
    .i_block7  (blocks[7]),
    .i_block8  (blocks[8]),
    .i_block9  (blocks[9]),
    .i_block10 (blocks[10]),
    .i_block11 (blocks[11]),
    .i_block12 (blocks[12]),
    .i_block13 (blocks[13]),
    .i_block14 (blocks[14]),
    .i_block15 (blocks[15]),
    .o_order   (order),
    .o_done    (done)
  );

  // Shifts each channel of a colour by +/-10 (alternating), clamped to 0..255.
  function automatic logic [23:0] addNoise(input logic [23:0] c, input int idx);
    logic [23:0] r;
    int v;
    r = c;
    for (int k = 0; k < 3; k++) begin
      v = int'(c[8*k +: 8]) + ((((idx + k) % 2) == 0) ? 10 : -10);
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      r[8*k +: 8] = v[7:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0][23:0] cols);
    @(negedge clk);
    for (int i = 0; i < 16; i++) blocks[i] = cols[i];
  endtask

  // Raises start for exactly one rising edge; returns on the negedge after it.
  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges until done is seen high, bounded by WAIT_LIMIT.
  task automatic waitDone(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < WAIT_LIMIT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
  endtask

  task automatic runVector(input vector_t v);
    int cyc;
    applyStimulus(v.colours);
    pulseStart();
    waitDone(cyc);
    checkOutput({v.name, "_latency"}, 64'(cyc), 64'(DONE_LATENCY));
    checkOutput({v.name, "_order"}, order, v.expOrder);
    @(negedge clk);
    checkOutput({v.name, "_donePulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int cyc;
    int cyc2;
    int n;
    logic [15:0][23:0] tmp;

    exactCols = '{24'h007fff, 24'h00ffff, 24'h0000ff, 24'hff7fff,
                  24'h7f00ff, 24'hff00ff, 24'h7fff00, 24'hffff00,
                  24'h007f00, 24'h00ff00, 24'h000000, 24'hffffff,
                  24'h7f7f00, 24'hff7f00, 24'hff0000, 24'h7f0000};
    // IDs: C A E 0 8 4 6 2 D B F 1 7 3 5 9
    expExact = 64'hCAE08462DBF17359;
    zeroCols = '0;

    vecs[0].name = "exact";
    for (int i = 0; i < 16; i++) vecs[0].colours[i] = exactCols[i];
    vecs[0].expOrder = expExact;

    vecs[1].name = "noisy";
    for (int i = 0; i < 16; i++) vecs[1].colours[i] = addNoise(exactCols[i], i);
    vecs[1].expOrder = expExact;

    vecs[2].name = "allZero";
    vecs[2].colours = zeroCols;
    vecs[2].expOrder = 64'hFFFF_FFFF_FFFF_FFFF;

    // 7f7f7f -> 7 (127, unique); bf7f00 ties 3/7 at 64 -> 3;
    // ffbfff ties 0/1 -> 0; 7fbf00 ties 6/7 -> 6; bfbf00 ties 2/3/6/7 -> 2.
    vecs[3].name = "tie";
    vecs[3].colours = zeroCols;
    vecs[3].colours[0] = 24'h7f7f7f;
    vecs[3].colours[1] = 24'hbf7f00;
    vecs[3].colours[2] = 24'hffbfff;
    vecs[3].colours[3] = 24'h7fbf00;
    vecs[3].colours[4] = 24'hbfbf00;
    vecs[3].expOrder = 64'h73062FFFFFFFFFFF;

    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) blocks[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetOrder", order, 64'd0);
    checkOutput("resetDone", {63'd0, done}, 64'd0);

    for (int v = 0; v < 4; v++) runVector(vecs[v]);

    // Second start and new input colours mid-run must not disturb the run.
    applyStimulus(vecs[0].colours);
    pulseStart();
    repeat (49) @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 16; i++) blocks[i] = '0;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc2);
    checkOutput("startInRun_latency", 64'(50 + cyc2), 64'(DONE_LATENCY));
    checkOutput("startInRun_order", order, expExact);
    countDones(300, n);
    checkOutput("startInRun_noRetrigger", 64'(n), 64'd0);

    // Order word holds while inputs wander after done.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) blocks[i] = 24'($urandom);
    end
    checkOutput("holdAfterDone", order, expExact);

    // Reset 100 cycles into a run aborts it cleanly.
    applyStimulus(vecs[2].colours);
    pulseStart();
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset_order", order, 64'd0);
    checkOutput("midReset_done", {63'd0, done}, 64'd0);
    countDones(300, n);
    checkOutput("midReset_noDone", 64'(n), 64'd0);
    runVector(vecs[3]);

    // Start held high retriggers back-to-back runs.
    applyStimulus(vecs[0].colours);
    start = 1'b1;
    @(negedge clk);
    waitDone(cyc);
    checkOutput("heldStart_first", 64'(cyc), 64'(DONE_LATENCY));
    checkOutput("heldStart_firstOrder", order, expExact);
    for (int i = 0; i < 16; i++) blocks[i] = vecs[2].colours[i];
    @(negedge clk);
    waitDone(cyc);
    start = 1'b0;
    checkOutput("heldStart_second", 64'(cyc), 64'(DONE_LATENCY));
    checkOutput("heldStart_secondOrder", order, 64'hFFFF_FFFF_FFFF_FFFF);

    tmp = zeroCols;
    applyStimulus(tmp);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
